vector_loader: RTL and testbench
================================

# vector_loader

UART-fed loader that writes `NVEC` byte vectors of `NBytes` each into per-vector BRAM write ports and decodes non-load bytes as processor commands. It sits between the board serial pin and the accelerator BRAMs/processor, generalising the two-vector loader to `NVEC` channels. It adds a receive timeout with abort, single-cycle write strobes and an explicit error/busy status.

## Interface
Parameters:
- `NBytes`, 1024, bytes per vector; `AW = max(1, $clog2(NBytes))`.
- `NVEC`, 2, number of vector BRAMs, 1..15.
- `CLKS_PER_BIT`, 100, passed to the internal `uart_rx` instance.
- `TIMEOUT`, 1_000_000, idle clocks allowed between bytes while loading; 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `uart_rx` in 1: serial receive line.
- `done` in 1: processor finished the current command.
- `bram_we` out NVEC: one-hot write strobe, one bit per vector BRAM.
- `bram_byte` out 8: write data.
- `bram_addr` out AW: write address.
- `result` out 4: command code, valid while `result_valid`.
- `result_valid` out 1: one-cycle command strobe.
- `vec_ready` out NVEC: vector k fully loaded.
- `busy` out 1: high in any state other than IDLE.
- `error` out 1: one-cycle pulse on load timeout.

## Operation
- Internal `uart_rx` provides `rx_dv` (1-cycle pulse) and `rx_byte`.
- FSM states: IDLE, LOAD, COMM. `k` is a register holding the active vector index. `addr` is an AW-bit counter.
- IDLE, on `rx_dv`:
  - If `rx_byte < NVEC`: set `k = rx_byte`, `addr = 0`, clear `vec_ready[k]`, clear the timeout counter, go to LOAD.
  - Otherwise: drive `result = rx_byte[3:0]` and `result_valid = 1` for one cycle, then go to COMM.
- LOAD, on `rx_dv`:
  - Assert `bram_we[k]` for one cycle with `bram_addr = addr` and `bram_byte = rx_byte`.
  - If `addr == NBytes-1`: set `vec_ready[k]` and go to IDLE.
  - Otherwise: `addr++` and clear the timeout counter.
- LOAD, no byte: the timeout counter increments. When it reaches `TIMEOUT` (if `TIMEOUT != 0`):
  - pulse `error`, go to IDLE;
  - `vec_ready[k]` stays 0;
  - bytes already written are not undone.
- COMM:
  - Received bytes are discarded.
  - When `done == 1`, go to IDLE.
  - `done` in IDLE or LOAD is ignored.
- Other `vec_ready` bits are unaffected by loading vector k. Reloading a vector clears only its own bit.
- Command byte values 0..NVEC-1 are never reported as commands.

## Timing
- All outputs are registered.
- Reset values:
  - `bram_we = 0`, `bram_byte = 0`, `bram_addr = 0`;
  - `result = 0`, `result_valid = 0`;
  - `vec_ready = 0`, `busy = 0`, `error = 0`;
  - state IDLE; the `uart_rx` instance is also reset.
- An `rx_dv` at cycle t gives its strobe/state effect at t+1: `bram_we`, `result_valid`, the `vec_ready` clear/set, and `busy`.
- `vec_ready[k]` rises in the same cycle as the final `bram_we[k]` strobe.
- `busy` falls in the same cycle as the final strobe, the `error` pulse, or one cycle after `done` is sampled in COMM.
- `bram_addr` and `bram_byte` hold their last values when `bram_we == 0`.
- `result` holds its last value; only `result_valid` pulses.
- Timeout boundary: a byte whose `rx_dv` arrives in the same cycle the counter reaches `TIMEOUT` is accepted, and no timeout occurs.
- Reset mid-load or mid-command: everything returns to reset values on the next edge, and any partial frame in `uart_rx` is dropped.
- Throughput: one byte per UART frame. `rx_dv` is never closer than 10·`CLKS_PER_BIT` cycles, so there are no back-to-back conflicts.

## Test plan
- Use `NBytes=4`, `NVEC=3`, `CLKS_PER_BIT=4`, `TIMEOUT=200` unless stated.
- Load vector 2: send 0x02, 0xA0, 0xA1, 0xA2, 0xA3.
  - Expect 4 `bram_we=3'b100` strobes at addr 0..3 with data A0..A3.
  - Expect `vec_ready=3'b100` with the last strobe, then `busy=0`.
- Command: send 0x07.
  - Expect `result_valid` for 1 cycle with `result=4'h7`, then `busy=1`.
  - Send 0x55 during COMM: expect no strobe.
  - Pulse `done`: expect `busy=0` one cycle later.
- Timeout: send 0x01, 0x11, then idle for more than 200 cycles.
  - Expect 1 strobe at addr 0, then an `error` pulse.
  - Expect `vec_ready[1]=0` and a return to IDLE.
  - A following 0x00 plus 4 bytes loads vector 0 normally.
- Reload clears the ready bit: load vectors 0 and 1 (`vec_ready=3'b011`), then send 0x00.
  - Expect `vec_ready=3'b010` at the next cycle.
  - Expect `3'b011` after 4 more bytes.
- Reset mid-load: send 0x00 and 2 data bytes, then assert `reset` for 1 cycle.
  - Expect all outputs at 0.
  - Then send 0x00 plus 4 bytes: expect addr restarting at 0.
- Byte 0x12 (≥NVEC, upper bits set): expect `result=4'h2` with `result_valid`, and no load.

Source files
------------

// File: rtl/vector_loader.sv
// vector_loader: UART-fed loader for NVEC byte vectors of NBytes each.
// A byte below NVEC selects a vector and starts a load of NBytes data bytes into that
// vector's BRAM write port; any other byte is reported as a processor command and the
// block waits for `done`. A receive timeout aborts a stalled load with an error pulse.
//
// Ports:
//   clk          - clock
//   reset        - synchronous active-high reset (also resets the serial receiver)
//   uart_rx      - serial receive line (8N1, idle high)
//   done         - processor finished the current command
//   bram_we      - one-hot single-cycle write strobe, one bit per vector BRAM
//   bram_byte    - write data (holds when no strobe)
//   bram_addr    - write address (holds when no strobe)
//   result       - command code, valid with result_valid
//   result_valid - one-cycle command strobe
//   vec_ready    - vector k fully loaded
//   busy         - FSM not idle
//   error        - one-cycle pulse on load timeout
module vector_loader #(
    parameter int unsigned NBytes       = 1024,
    parameter int unsigned NVEC         = 2,
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned TIMEOUT      = 1_000_000,
    parameter int unsigned AW           = (NBytes > 1) ? $clog2(NBytes) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            uart_rx,
    input  logic            done,
    output logic [NVEC-1:0] bram_we,
    output logic [7:0]      bram_byte,
    output logic [AW-1:0]   bram_addr,
    output logic [3:0]      result,
    output logic            result_valid,
    output logic [NVEC-1:0] vec_ready,
    output logic            busy,
    output logic            error
);

    localparam int unsigned KW    = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned RxMid = (CLKS_PER_BIT - 1) / 2;

    // ------------------------------------------------------------------
    // Serial receiver: two-flop synchroniser, mid-bit sampling, 8N1.
    // ------------------------------------------------------------------
    localparam logic [1:0] RxIdle  = 2'd0;
    localparam logic [1:0] RxStart = 2'd1;
    localparam logic [1:0] RxData  = 2'd2;
    localparam logic [1:0] RxStop  = 2'd3;

    logic          rx_meta_q, rx_sync_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_dv_q, rx_dv_d;
    logic [7:0]    rx_byte_q, rx_byte_d;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_dv_d    = 1'b0;
        rx_byte_d  = rx_byte_q;
        case (rx_st_q)
            RxIdle: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_sync_q) rx_st_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == CW'(RxMid)) begin
                    rx_cnt_d = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    rx_st_d  = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_st_d = RxStop;
                    else                  rx_bit_d = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_d = '0;
                    rx_st_d  = RxIdle;
                    // Frames with a bad stop bit are dropped.
                    if (rx_sync_q) begin
                        rx_dv_d   = 1'b1;
                        rx_byte_d = rx_shift_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_st_q    <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_dv_q    <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_dv_q    <= rx_dv_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Loader / command FSM
    // ------------------------------------------------------------------
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StComm = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [NVEC-1:0] we_q, we_d;
    logic [7:0]      byte_q, byte_d;
    logic [AW-1:0]   baddr_q, baddr_d;
    logic [3:0]      result_q, result_d;
    logic            rv_q, rv_d;
    logic [NVEC-1:0] ready_q, ready_d;
    logic            busy_q;
    logic            err_q, err_d;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        addr_d   = addr_q;
        tcnt_d   = tcnt_q;
        we_d     = '0;
        byte_d   = byte_q;
        baddr_d  = baddr_q;
        result_d = result_q;
        rv_d     = 1'b0;
        ready_d  = ready_q;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (rx_dv_q) begin
                    if (32'(rx_byte_q) < NVEC) begin
                        k_d     = rx_byte_q[KW-1:0];
                        addr_d  = '0;
                        tcnt_d  = '0;
                        state_d = StLoad;
                        for (int i = 0; i < int'(NVEC); i++) begin
                            if (rx_byte_q == 8'(i)) ready_d[i] = 1'b0;
                        end
                    end else begin
                        result_d = rx_byte_q[3:0];
                        rv_d     = 1'b1;
                        state_d  = StComm;
                    end
                end
            end
            StLoad: begin
                // A byte arriving on the cycle the counter hits TIMEOUT wins.
                if (rx_dv_q) begin
                    for (int i = 0; i < int'(NVEC); i++) begin
                        if (k_q == KW'(i)) we_d[i] = 1'b1;
                    end
                    byte_d  = rx_byte_q;
                    baddr_d = addr_q;
                    if (addr_q == AW'(NBytes - 1)) begin
                        for (int i = 0; i < int'(NVEC); i++) begin
                            if (k_q == KW'(i)) ready_d[i] = 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        tcnt_d = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    if (tcnt_q == TW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            StComm: begin
                if (done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            addr_q   <= '0;
            tcnt_q   <= '0;
            we_q     <= '0;
            byte_q   <= '0;
            baddr_q  <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            ready_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            tcnt_q   <= tcnt_d;
            we_q     <= we_d;
            byte_q   <= byte_d;
            baddr_q  <= baddr_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            ready_q  <= ready_d;
            busy_q   <= (state_d != StIdle);
            err_q    <= err_d;
        end
    end

    assign bram_we      = we_q;
    assign bram_byte    = byte_q;
    assign bram_addr    = baddr_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign vec_ready    = ready_q;
    assign busy         = busy_q;
    assign error        = err_q;

endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader with NBytes=4, NVEC=3, CLKS_PER_BIT=4, TIMEOUT=200.
module tb_vector_loader;
    localparam int NB  = 4;
    localparam int NV  = 3;
    localparam int CPB = 4;
    localparam int TO  = 200;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          uart_rx = 1'b1;
    logic          done = 1'b0;
    logic [NV-1:0] bram_we;
    logic [7:0]    bram_byte;
    logic [1:0]    bram_addr;
    logic [3:0]    result;
    logic          result_valid;
    logic [NV-1:0] vec_ready;
    logic          busy;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    vector_loader #(
        .NBytes(NB), .NVEC(NV), .CLKS_PER_BIT(CPB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .done(done),
        .bram_we(bram_we), .bram_byte(bram_byte), .bram_addr(bram_addr),
        .result(result), .result_valid(result_valid), .vec_ready(vec_ready),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Event log sampled on the falling edge.
    logic [NV-1:0] we_log[16];
    logic [1:0]    addr_log[16];
    logic [7:0]    data_log[16];
    logic [NV-1:0] vr_log[16];
    logic          busy_log[16];
    int            n_we = 0;
    logic [3:0]    res_log;
    logic          busy_at_rv;
    int            n_rv = 0;
    logic [NV-1:0] vr_at_err;
    logic          busy_at_err;
    int            n_err = 0;
    logic [NV-1:0] vr_at_rise;
    int            n_rise = 0;
    int            n_long = 0;
    logic          rv_p = 1'b0, err_p = 1'b0, busy_p = 1'b0;
    logic [NV-1:0] we_p = '0;

    always @(negedge clk) begin
        if (bram_we != '0) begin
            if (n_we < 16) begin
                we_log[n_we]   = bram_we;
                addr_log[n_we] = bram_addr;
                data_log[n_we] = bram_byte;
                vr_log[n_we]   = vec_ready;
                busy_log[n_we] = busy;
            end
            n_we++;
        end
        if (result_valid === 1'b1) begin
            res_log    = result;
            busy_at_rv = busy;
            n_rv++;
        end
        if (error === 1'b1) begin
            vr_at_err   = vec_ready;
            busy_at_err = busy;
            n_err++;
        end
        if (busy === 1'b1 && busy_p === 1'b0) begin
            vr_at_rise = vec_ready;
            n_rise++;
        end
        if ((result_valid === 1'b1 && rv_p === 1'b1) || (error === 1'b1 && err_p === 1'b1) ||
            (bram_we != '0 && we_p != '0)) n_long++;
        rv_p   = result_valid;
        err_p  = error;
        busy_p = busy;
        we_p   = bram_we;
    end

    task automatic clr_log();
        n_we = 0; n_rv = 0; n_err = 0; n_rise = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic load_vec(input logic [7:0] k, input logic [7:0] base);
        send_byte(k);
        for (int i = 0; i < NB; i++) send_byte(base + 8'(i));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bram_we !== 3'b000) begin n_fail++; $display("FAIL reset_we got %b want 000", bram_we); end
        n_checks++; if (bram_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", bram_byte); end
        n_checks++; if (bram_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bram_addr); end
        n_checks++; if ({result, result_valid} !== 5'd0) begin n_fail++; $display("FAIL reset_result got %h/%b want 0/0", result, result_valid); end
        n_checks++; if ({vec_ready, busy, error} !== 5'd0) begin n_fail++; $display("FAIL reset_status got %b/%b/%b want 000/0/0", vec_ready, busy, error); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clr_log();
    endtask

    task automatic test_load_vec2();
        clr_log();
        load_vec(8'h02, 8'hA0);
        n_checks++; if (n_we !== 4) begin n_fail++; $display("FAIL load2_count got %0d want 4", n_we); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (we_log[i] !== 3'b100 || addr_log[i] !== 2'(i) || data_log[i] !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL load2_strobe%0d got we=%b a=%0d d=%h want we=100 a=%0d d=%h",
                         i, we_log[i], addr_log[i], data_log[i], i, 8'hA0 + 8'(i));
            end
        end
        n_checks++; if (vr_log[2] !== 3'b000 || busy_log[2] !== 1'b1) begin n_fail++; $display("FAIL load2_mid got vr=%b busy=%b want 000/1", vr_log[2], busy_log[2]); end
        n_checks++; if (vr_log[3] !== 3'b100 || busy_log[3] !== 1'b0) begin n_fail++; $display("FAIL load2_last got vr=%b busy=%b want 100/0", vr_log[3], busy_log[3]); end
        n_checks++; if (vec_ready !== 3'b100 || busy !== 1'b0) begin n_fail++; $display("FAIL load2_after got vr=%b busy=%b want 100/0", vec_ready, busy); end
        n_checks++; if (bram_addr !== 2'd3 || bram_byte !== 8'hA3) begin n_fail++; $display("FAIL load2_hold got a=%0d d=%h want 3/a3", bram_addr, bram_byte); end
        n_checks++; if (n_rv !== 0 || n_err !== 0) begin n_fail++; $display("FAIL load2_noside got rv=%0d err=%0d want 0/0", n_rv, n_err); end
    endtask

    task automatic test_command();
        clr_log();
        send_byte(8'h07);
        n_checks++; if (n_rv !== 1 || res_log !== 4'h7) begin n_fail++; $display("FAIL cmd_strobe got n=%0d r=%h want 1/7", n_rv, res_log); end
        n_checks++; if (busy_at_rv !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL cmd_busy got %b/%b want 1/1", busy_at_rv, busy); end
        n_checks++; if (result !== 4'h7 || result_valid !== 1'b0) begin n_fail++; $display("FAIL cmd_hold got r=%h v=%b want 7/0", result, result_valid); end
        send_byte(8'h55);
        n_checks++; if (n_we !== 0 || n_rv !== 1 || busy !== 1'b1) begin n_fail++; $display("FAIL cmd_discard got we=%0d rv=%0d busy=%b want 0/1/1", n_we, n_rv, busy); end
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cmd_done got busy=%b want 0", busy); end
        n_checks++; if (vec_ready !== 3'b100) begin n_fail++; $display("FAIL cmd_ready got %b want 100", vec_ready); end
    endtask

    task automatic test_timeout();
        clr_log();
        send_byte(8'h01);
        send_byte(8'h11);
        n_checks++; if (n_we !== 1 || we_log[0] !== 3'b010 || addr_log[0] !== 2'd0 || data_log[0] !== 8'h11) begin
            n_fail++; $display("FAIL to_strobe got n=%0d we=%b a=%0d d=%h want 1/010/0/11", n_we, we_log[0], addr_log[0], data_log[0]);
        end
        n_checks++; if (n_err !== 0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_early got err=%0d busy=%b want 0/1", n_err, busy); end
        for (int c = 0; c < 300 && n_err == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++; if (n_err !== 1) begin n_fail++; $display("FAIL to_error got %0d pulses want 1", n_err); end
        n_checks++; if (vr_at_err !== 3'b100 || busy_at_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL to_state got vr=%b busy=%b/%b want 100/0/0", vr_at_err, busy_at_err, busy);
        end
        clr_log();
        load_vec(8'h00, 8'h30);
        n_checks++; if (n_we !== 4 || addr_log[0] !== 2'd0 || addr_log[3] !== 2'd3 || we_log[3] !== 3'b001 || data_log[3] !== 8'h33) begin
            n_fail++; $display("FAIL to_reload got n=%0d a0=%0d a3=%0d we=%b d=%h want 4/0/3/001/33", n_we, addr_log[0], addr_log[3], we_log[3], data_log[3]);
        end
        n_checks++; if (vec_ready !== 3'b101 || n_err !== 0) begin n_fail++; $display("FAIL to_ready got vr=%b err=%0d want 101/0", vec_ready, n_err); end
    endtask

    task automatic test_reload();
        pulse_reset();
        load_vec(8'h00, 8'h40);
        load_vec(8'h01, 8'h50);
        n_checks++; if (vec_ready !== 3'b011) begin n_fail++; $display("FAIL reload_pre got %b want 011", vec_ready); end
        clr_log();
        send_byte(8'h00);
        n_checks++; if (n_rise !== 1 || vr_at_rise !== 3'b010) begin n_fail++; $display("FAIL reload_clear got n=%0d vr=%b want 1/010", n_rise, vr_at_rise); end
        for (int i = 0; i < NB; i++) send_byte(8'h60 + 8'(i));
        n_checks++; if (vec_ready !== 3'b011 || n_we !== 4) begin n_fail++; $display("FAIL reload_post got vr=%b n=%0d want 011/4", vec_ready, n_we); end
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'h00);
        send_byte(8'h70);
        send_byte(8'h71);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy got %b want 1", busy); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({bram_we, bram_byte, bram_addr, result, result_valid, vec_ready, busy, error} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs got we=%b d=%h a=%0d r=%h v=%b vr=%b busy=%b err=%b want all 0",
                               bram_we, bram_byte, bram_addr, result, result_valid, vec_ready, busy, error);
        end
        reset = 1'b0;
        clr_log();
        load_vec(8'h00, 8'h80);
        n_checks++; if (n_we !== 4 || addr_log[0] !== 2'd0 || data_log[0] !== 8'h80 || addr_log[3] !== 2'd3) begin
            n_fail++; $display("FAIL midrst_restart got n=%0d a0=%0d d0=%h a3=%0d want 4/0/80/3", n_we, addr_log[0], data_log[0], addr_log[3]);
        end
        n_checks++; if (vec_ready !== 3'b001) begin n_fail++; $display("FAIL midrst_ready got %b want 001", vec_ready); end
    endtask

    task automatic test_high_cmd();
        clr_log();
        send_byte(8'h12);
        n_checks++; if (n_rv !== 1 || res_log !== 4'h2 || n_we !== 0) begin n_fail++; $display("FAIL hicmd got rv=%0d r=%h we=%0d want 1/2/0", n_rv, res_log, n_we); end
        n_checks++; if (busy !== 1'b1 || vec_ready !== 3'b001) begin n_fail++; $display("FAIL hicmd_state got busy=%b vr=%b want 1/001", busy, vec_ready); end
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hicmd_done got busy=%b want 0", busy); end
        n_checks++; if (n_long !== 0) begin n_fail++; $display("FAIL pulse_width got %0d long pulses want 0", n_long); end
    endtask

    initial begin
        test_reset();
        test_load_vec2();
        test_command();
        test_timeout();
        test_reload();
        test_reset_mid_load();
        test_high_cmd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
